// File: rtl/csr_pkg.sv
// Shared definitions for the CSR host sequencer.
//   - field widths of one CSR entry and of the spike train
//   - default idle timeout and timer width
//   - FSM state encoding (4 bits)
//   - packed entry type and the spike-beat formatting helper
package csr_pkg;

  localparam int ROW_W   = 2;
  localparam int COL_W   = 2;
  localparam int VAL_W   = 8;
  localparam int SPIKE_W = 4;
  localparam int ENTRY_W = ROW_W + COL_W + VAL_W;

  localparam int TIMEOUT_DEF = 255;
  localparam int TMR_W       = 8;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_START    = 4'd1;
  localparam logic [3:0] S_WAIT_RDY = 4'd2;
  localparam logic [3:0] S_BEAT     = 4'd3;
  localparam logic [3:0] S_GAP      = 4'd4;
  localparam logic [3:0] S_LIST_END = 4'd5;
  localparam logic [3:0] S_SETTLE   = 4'd6;
  localparam logic [3:0] S_TRAIN    = 4'd7;
  localparam logic [3:0] S_COLLECT  = 4'd8;
  localparam logic [3:0] S_FINISH   = 4'd9;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [VAL_W-1:0] val;
  } csr_entry_t;

  // The spike train rides in the low bits of the value bus.
  function automatic logic [VAL_W-1:0] spike_word(input logic [SPIKE_W-1:0] s);
    return {{(VAL_W-SPIKE_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/csr_host_sequencer_if.sv
// Accelerator CPU load port as seen from the host sequencer.
//   fetch_ready  accelerator -> host  accelerator can take a beat
//   sending_out  accelerator -> host  toggles once per result event
//   output_val   accelerator -> host  result data
//   start        host -> accelerator  one-cycle run start
//   row_val      host -> accelerator  entry row index
//   column_val   host -> accelerator  entry column index
//   value        host -> accelerator  entry value or spike word
//   sending_cpu  host -> accelerator  data beat strobe
//   done_list    host -> accelerator  end-of-list strobe
// master: host sequencer side; slave: accelerator side.
interface csr_host_sequencer_if;
  import csr_pkg::*;

  logic             fetch_ready;
  logic             sending_out;
  logic [VAL_W-1:0] output_val;
  logic             start;
  logic [ROW_W-1:0] row_val;
  logic [COL_W-1:0] column_val;
  logic [VAL_W-1:0] value;
  logic             sending_cpu;
  logic             done_list;

  modport master (
    input  fetch_ready, sending_out, output_val,
    output start, row_val, column_val, value, sending_cpu, done_list
  );

  modport slave (
    output fetch_ready, sending_out, output_val,
    input  start, row_val, column_val, value, sending_cpu, done_list
  );

endinterface

// File: rtl/csr_entry_buf.sv
// Append-only CSR entry register file.
//   clk, rst_n  clock; asynchronous active-high reset (contents are lost)
//   wr_en       append wr_data if not full, else set overflow
//   clr         empty the buffer and clear overflow (wins over wr_en)
//   wr_data     entry to append
//   rd_idx      combinational read index
//   rd_data     entry at rd_idx
//   count       number of stored entries (0..DEPTH)
//   overflow    sticky: a write arrived while full
module csr_entry_buf
  import csr_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic                       clr,
  input  csr_entry_t                 wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output csr_entry_t                 rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  csr_entry_t mem [DEPTH];
  logic       full;

  assign full    = (count == CNT_W'(DEPTH));
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      if (full) begin
        overflow <= 1'b1;
      end else begin
        mem[count[IDX_W-1:0]] <= wr_data;
        count                 <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_host_sequencer.sv
// Host-side sequencer for the sparse MVM accelerator CPU load port.
// Streams the buffered CSR entries, the end-of-list strobe and the spike
// beat, then collects N_ROWS result words signalled by sending_out toggles.
//   clk, rst_n    clock; asynchronous active-high reset
//   wr_en, wr_row, wr_col, wr_val   append an entry (idle only)
//   spike_in      spike train, captured on go
//   clr           empty buffer, clear overflow (idle only)
//   go            start a run (ignored while busy)
//   acc           accelerator port (master side)
//   busy          run in progress
//   done          one-cycle successful completion pulse
//   err_timeout   sticky wait-state timeout, cleared by the next go
//   overflow      sticky buffer overflow, cleared by clr
//   results       row r in bits [8r+7:8r]
//
// state      | meaning
// IDLE       | accept writes/clr, wait for go
// START      | start pulse to the accelerator
// WAIT_RDY   | wait for fetch_ready (timed)
// BEAT       | one entry on the bus with sending_cpu
// GAP        | one cycle for fetch_ready to drop
// LIST_END   | done_list pulse
// SETTLE     | fixed two-cycle pause
// TRAIN      | spike beat with sending_cpu
// COLLECT    | capture results on sending_out toggles (timed)
// FINISH     | done pulse, back to IDLE
module csr_host_sequencer
  import csr_pkg::*;
#(
  parameter int MAX_NNZ = 16,
  parameter int N_ROWS  = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [COL_W-1:0]      wr_col,
  input  logic [VAL_W-1:0]      wr_val,
  input  logic [SPIKE_W-1:0]    spike_in,
  input  logic                  clr,
  input  logic                  go,
  csr_host_sequencer_if.master  acc,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout,
  output logic                  overflow,
  output logic [8*N_ROWS-1:0]   results
);

  localparam int IDX_W  = $clog2(MAX_NNZ);
  localparam int CNT_W  = IDX_W + 1;
  localparam int RIDX_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [TMR_W-1:0]  TMR_LOAD    = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(2);
  localparam logic [RIDX_W-1:0] LAST_ROW    = RIDX_W'(N_ROWS - 1);

  logic [3:0]         state;
  logic [CNT_W-1:0]   idx;
  logic [RIDX_W-1:0]  ridx;
  logic               marker_seen;
  logic               so_hist;
  logic [SPIKE_W-1:0] spike;
  logic [TMR_W-1:0]   tmr;

  logic               idle;
  logic               toggle;
  csr_entry_t         wr_entry;
  csr_entry_t         rd_entry;
  logic [CNT_W-1:0]   count;

  assign idle     = (state == S_IDLE);
  assign toggle   = (acc.sending_out != so_hist);
  assign wr_entry = {wr_row, wr_col, wr_val};

  csr_entry_buf #(.DEPTH(MAX_NNZ)) u_entry_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en & idle),
    .clr      (clr & idle),
    .wr_data  (wr_entry),
    .rd_idx   (idx[IDX_W-1:0]),
    .rd_data  (rd_entry),
    .count    (count),
    .overflow (overflow)
  );

  // Outputs are registered: each one is set on the transition into the
  // state that owns it, so it is visible exactly during that state.
  // tmr is a down-counter shared by the timed waits and SETTLE; it is never
  // live in two states at once. Loaded with TIMEOUT, expiring on 1, a wait
  // state therefore lasts at most TIMEOUT cycles.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      ridx            <= '0;
      marker_seen     <= 1'b0;
      so_hist         <= 1'b0;
      spike           <= '0;
      tmr             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_timeout     <= 1'b0;
      results         <= '0;
      acc.start       <= 1'b0;
      acc.row_val     <= '0;
      acc.column_val  <= '0;
      acc.value       <= '0;
      acc.sending_cpu <= 1'b0;
      acc.done_list   <= 1'b0;
    end else begin
      acc.start       <= 1'b0;
      acc.row_val     <= '0;
      acc.column_val  <= '0;
      acc.value       <= '0;
      acc.sending_cpu <= 1'b0;
      acc.done_list   <= 1'b0;
      done            <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go) begin
            state       <= S_START;
            acc.start   <= 1'b1;
            busy        <= 1'b1;
            spike       <= spike_in;
            err_timeout <= 1'b0;
            idx         <= '0;
            ridx        <= '0;
            marker_seen <= 1'b0;
            so_hist     <= acc.sending_out;
          end
        end

        S_START: begin
          state <= S_WAIT_RDY;
          tmr   <= TMR_LOAD;
        end

        S_WAIT_RDY: begin
          if (acc.fetch_ready) begin
            if (idx < count) begin
              state           <= S_BEAT;
              acc.sending_cpu <= 1'b1;
              acc.row_val     <= rd_entry.row;
              acc.column_val  <= rd_entry.col;
              acc.value       <= rd_entry.val;
              idx             <= idx + 1'b1;
            end else begin
              state         <= S_LIST_END;
              acc.done_list <= 1'b1;
            end
          end else if (tmr == TMR_W'(1)) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_BEAT: begin
          state <= S_GAP;
        end

        // One cycle is the minimum and the maximum here, so fetch_ready
        // dropping earlier cannot shorten it.
        S_GAP: begin
          state <= S_WAIT_RDY;
          tmr   <= TMR_LOAD;
        end

        S_LIST_END: begin
          state <= S_SETTLE;
          tmr   <= SETTLE_LOAD;
        end

        S_SETTLE: begin
          if (tmr == TMR_W'(1)) begin
            state           <= S_TRAIN;
            acc.sending_cpu <= 1'b1;
            acc.value       <= spike_word(spike);
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_TRAIN: begin
          state <= S_COLLECT;
          tmr   <= TMR_LOAD;
        end

        // A toggle is a level difference against the history bit; the first
        // one after go only frames the result stream and carries no data.
        S_COLLECT: begin
          if (toggle) begin
            so_hist <= acc.sending_out;
            tmr     <= TMR_LOAD;
            if (!marker_seen) begin
              marker_seen <= 1'b1;
            end else begin
              results[VAL_W*int'(ridx) +: VAL_W] <= acc.output_val;
              if (ridx == LAST_ROW) state <= S_FINISH;
              else                  ridx  <= ridx + 1'b1;
            end
          end else if (tmr == TMR_W'(1)) begin
            state       <= S_IDLE;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end

        S_FINISH: begin
          state <= S_IDLE;
          done  <= 1'b1;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_host_sequencer.sv
module tb_csr_host_sequencer;
  import csr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [7:0] wr_val = '0;
  logic [3:0] spike_in = '0;
  logic       clr = 1'b0;
  logic       go = 1'b0;
  logic       busy, done, err_timeout, overflow;
  logic [31:0] results;

  csr_host_sequencer_if acc ();

  csr_host_sequencer #(.MAX_NNZ(16), .N_ROWS(4), .TIMEOUT(255)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_val      (wr_val),
    .spike_in    (spike_in),
    .clr         (clr),
    .go          (go),
    .acc         (acc),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .overflow    (overflow),
    .results     (results)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [11:0] ent_q[$];
  logic [7:0]  res_m[4];
  logic [3:0]  spike_m;
  logic [7:0]  tog_vals[5];

  int total = 0;
  int bad = 0;

  // per-run observations
  logic [11:0] beats[$];
  int          beat_cyc[$];
  int start_cnt, start_cyc, dl_cnt, dl_cyc, train_cnt, train_cyc;
  int done_cnt, err_cyc, zero_viol, lat_bad, rdy_hi_cyc;
  logic [7:0] train_val;
  bit busy_at_done, busy_at_err, err_at_start, rst_zero, budget_hit;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [1:0] r, input logic [1:0] c, input logic [7:0] v);
    @(negedge clk);
    wr_en = 1'b1; wr_row = r; wr_col = c; wr_val = v;
    @(negedge clk);
    wr_en = 1'b0;
    if (ent_q.size() < 16) ent_q.push_back({r, c, v});
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ent_q.delete();
  endtask

  task automatic rand_togs();
    for (int i = 0; i < 5; i++) tog_vals[i] = 8'($urandom);
  endtask

  // Behavioural accelerator: one loop iteration per cycle, observing at
  // the falling edge and then driving the accelerator-side inputs.
  // mode 0: random fetch_ready, 1: held low, 2: held high, 3: high from cycle 4
  task automatic run(input int mode, input int n_tog, input int go_at, input int rst_at);
    int wait_t, tog_idx, chk_slot, tail;
    logic [7:0] chk_val;
    beats.delete(); beat_cyc.delete();
    start_cnt = 0; dl_cnt = 0; train_cnt = 0; done_cnt = 0;
    start_cyc = -1; dl_cyc = -1; train_cyc = -1; err_cyc = -1; rdy_hi_cyc = -1;
    zero_viol = 0; lat_bad = 0; train_val = '0;
    busy_at_done = 1'b1; busy_at_err = 1'b1; err_at_start = 1'b1;
    rst_zero = 1'b0; budget_hit = 1'b1;
    wait_t = -1; tog_idx = 0; chk_slot = -1; tail = 0; chk_val = '0;
    @(negedge clk);
    acc.fetch_ready = 1'b0;
    spike_in = spike_m;
    go = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (chk_slot >= 0) begin
        if (results[8*chk_slot +: 8] !== chk_val) lat_bad++;
        chk_slot = -1;
      end
      if (rst_at > 0 && tog_idx == rst_at) begin
        rst_n = 1'b1;
        #1;
        rst_zero = ({acc.start, acc.sending_cpu, acc.done_list, acc.row_val,
                     acc.column_val, acc.value, busy, done, err_timeout,
                     overflow, results} === '0);
        budget_hit = 1'b0;
        break;
      end
      if (acc.start) begin start_cnt++; start_cyc = cyc; err_at_start = err_timeout; end
      if (acc.sending_cpu) begin
        if (dl_cnt == 0) begin
          beats.push_back({acc.row_val, acc.column_val, acc.value});
          beat_cyc.push_back(cyc);
        end else begin
          train_cnt++; train_cyc = cyc; train_val = acc.value;
        end
      end else if ({acc.row_val, acc.column_val, acc.value} !== 12'h000) begin
        zero_viol++;
      end
      if (acc.done_list) begin dl_cnt++; dl_cyc = cyc; end
      if (done) begin done_cnt++; busy_at_done = busy; end
      if (err_timeout && err_cyc < 0 && start_cnt > 0) begin err_cyc = cyc; busy_at_err = busy; end
      if (cyc > 0 && !busy) tail++;
      if (tail > 3) begin budget_hit = 1'b0; break; end

      go = (cyc == go_at);
      spike_in = (cyc == go_at) ? ~spike_m : spike_m;
      case (mode)
        0: acc.fetch_ready = ($urandom_range(0, 2) != 0);
        1: acc.fetch_ready = 1'b0;
        2: acc.fetch_ready = 1'b1;
        default: begin
          acc.fetch_ready = (cyc >= 4);
          if (cyc == 4) rdy_hi_cyc = cyc;
        end
      endcase
      if (train_cnt > 0 && tog_idx < n_tog) begin
        if (wait_t < 0) wait_t = $urandom_range(1, 3);
        else if (wait_t == 0) begin
          acc.output_val = tog_vals[tog_idx];
          acc.sending_out = ~acc.sending_out;
          if (tog_idx >= 1 && tog_idx <= 4) begin
            chk_slot = tog_idx - 1;
            chk_val = tog_vals[tog_idx];
          end
          tog_idx++;
          wait_t = $urandom_range(1, 4);
        end else wait_t--;
      end
    end
    go = 1'b0;
    acc.fetch_ready = 1'b0;
  endtask

  task automatic check_run(input bit exp_list, input bit exp_done, input int n_tog);
    chk("budget", budget_hit, 0);
    chk("start_cnt", start_cnt, 1);
    chk("beat_cnt", beats.size(), exp_list ? ent_q.size() : 0);
    for (int i = 0; i < beats.size() && i < ent_q.size(); i++)
      chk($sformatf("beat_data[%0d]", i), beats[i], ent_q[i]);
    chk("done_list_cnt", dl_cnt, exp_list);
    if (exp_list) begin
      chk("train_cnt", train_cnt, 1);
      chk("train_val", train_val, {4'b0, spike_m});
      chk("settle_gap", train_cyc - dl_cyc, 3);
      for (int k = 1; k < n_tog && k <= 4; k++) res_m[k-1] = tog_vals[k];
    end
    chk("done_cnt", done_cnt, exp_done);
    if (exp_done) chk("busy_at_done", busy_at_done, 0);
    chk("err_timeout", err_timeout, !exp_done);
    chk("err_clr_at_go", err_at_start, 0);
    chk("busy_end", busy, 0);
    chk("idle_fields_zero", zero_viol, 0);
    chk("result_latency", lat_bad, 0);
    chk("results", results, {res_m[3], res_m[2], res_m[1], res_m[0]});
  endtask

  initial begin
    acc.fetch_ready = 1'b0;
    acc.sending_out = 1'b0;
    acc.output_val = '0;
    for (int i = 0; i < 4; i++) res_m[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outs", {acc.start, acc.sending_cpu, acc.done_list, acc.row_val,
                       acc.column_val, acc.value, busy, done, err_timeout,
                       overflow, results}, 0);

    // directed list from the plan
    wr(2'd0, 2'd1, 8'd5);
    wr(2'd1, 2'd0, 8'd7);
    wr(2'd3, 2'd2, 8'd9);
    spike_m = 4'b0111;
    tog_vals[0] = 8'h3C; tog_vals[1] = 8'h05; tog_vals[2] = 8'h07;
    tog_vals[3] = 8'h00; tog_vals[4] = 8'h09;
    run(0, 5, -1, -1);
    check_run(1, 1, 5);
    chk("plan_results", results, 32'h09_00_07_05);
    chk("plan_spike_beat", train_val, 8'h07);

    // replay with fetch_ready always high: best-case beat spacing
    spike_m = 4'($urandom);
    rand_togs();
    run(2, 5, -1, -1);
    check_run(1, 1, 5);
    if (beat_cyc.size() > 0) chk("first_beat_lat", beat_cyc[0] - start_cyc, 2);
    for (int i = 1; i < beat_cyc.size(); i++) chk("beat_gap", beat_cyc[i] - beat_cyc[i-1], 3);

    // overflow, full list, go pulsed mid-stream
    do_clr();
    for (int i = 0; i < 17; i++) wr(2'($urandom), 2'($urandom), 8'($urandom));
    chk("overflow_set", overflow, 1);
    spike_m = 4'($urandom);
    rand_togs();
    run(0, 5, 7, -1);
    check_run(1, 1, 5);
    do_clr();
    chk("overflow_clr", overflow, 0);

    // empty list
    spike_m = 4'($urandom);
    rand_togs();
    run(3, 5, -1, -1);
    check_run(1, 1, 5);
    chk("empty_dl_lat", dl_cyc - rdy_hi_cyc, 1);

    // fetch_ready never rises
    wr(2'($urandom), 2'($urandom), 8'($urandom));
    wr(2'($urandom), 2'($urandom), 8'($urandom));
    spike_m = 4'($urandom);
    run(1, 5, -1, -1);
    check_run(0, 0, 0);
    chk("wait_rdy_timeout_cyc", err_cyc - start_cyc, 256);
    chk("busy_at_err", busy_at_err, 0);

    // marker plus two results, then silence
    spike_m = 4'($urandom);
    rand_togs();
    run(0, 3, -1, -1);
    check_run(1, 0, 3);
    chk("collect_timeout_busy", busy_at_err, 0);

    // reset during COLLECT, then a fresh run
    spike_m = 4'($urandom);
    rand_togs();
    run(0, 5, -1, 2);
    chk("rst_budget", budget_hit, 0);
    chk("rst_all_zero", rst_zero, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    ent_q.delete();
    for (int i = 0; i < 4; i++) res_m[i] = '0;
    @(negedge clk);
    chk("results_after_rst", results, 0);
    wr(2'($urandom), 2'($urandom), 8'($urandom));
    wr(2'($urandom), 2'($urandom), 8'($urandom));
    spike_m = 4'($urandom);
    rand_togs();
    run(0, 5, -1, -1);
    check_run(1, 1, 5);

    // random lists
    for (int n = 0; n < 3; n++) begin
      int cnt;
      do_clr();
      cnt = $urandom_range(0, 16);
      for (int i = 0; i < cnt; i++) wr(2'($urandom), 2'($urandom), 8'($urandom));
      spike_m = 4'($urandom);
      rand_togs();
      run(0, 5, -1, -1);
      check_run(1, 1, 5);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
